// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate, occupancy, rush-hour and display blocks.
package parking_pkg;

   localparam int unsigned DEFAULT_CAPACITY = 3;

   typedef enum logic [2:0] {
      IDLE,
      ENT1,
      ENT2,
      ENT3,
      EXT1,
      EXT2,
      EXT3
   } gate_state_e;

   typedef struct packed {
      logic outer;
      logic inner;
   } sensor_pair_t;

endpackage : parking_pkg

// File: rtl/gate_sensor_fsm.sv
// Decodes complete car entries/exits from the two-beam gate sensor pair.
// Emits registered one-cycle enter_evt / exit_evt pulses.
module gate_sensor_fsm
   import parking_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  sensor_pair_t sensors,
   input  logic         clear,
   output logic         enter_evt,
   output logic         exit_evt
);

   gate_state_e state_q, state_d;
   logic        enter_evt_q, enter_evt_d;
   logic        exit_evt_q, exit_evt_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         enter_evt_q <= 1'b0;
         exit_evt_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         enter_evt_q <= enter_evt_d;
         exit_evt_q  <= exit_evt_d;
      end
   end

   // Sensor patterns are {outer, inner}; exit states mirror entry states.
   always_comb begin
      state_d     = state_q;
      enter_evt_d = 1'b0;
      exit_evt_d  = 1'b0;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               case (sensors)
                  2'b10:   state_d = ENT1;
                  2'b01:   state_d = EXT1;
                  default: state_d = IDLE;
               endcase
            end
            ENT1: begin
               case (sensors)
                  2'b11:   state_d = ENT2;
                  2'b10:   state_d = ENT1;
                  default: state_d = IDLE;
               endcase
            end
            ENT2: begin
               case (sensors)
                  2'b01:   state_d = ENT3;
                  2'b10:   state_d = ENT1;
                  2'b00:   state_d = IDLE;
                  default: state_d = ENT2;
               endcase
            end
            ENT3: begin
               case (sensors)
                  2'b00: begin
                     state_d     = IDLE;
                     enter_evt_d = 1'b1;
                  end
                  2'b11:   state_d = ENT2;
                  2'b10:   state_d = IDLE;
                  default: state_d = ENT3;
               endcase
            end
            EXT1: begin
               case (sensors)
                  2'b11:   state_d = EXT2;
                  2'b01:   state_d = EXT1;
                  default: state_d = IDLE;
               endcase
            end
            EXT2: begin
               case (sensors)
                  2'b10:   state_d = EXT3;
                  2'b01:   state_d = EXT1;
                  2'b00:   state_d = IDLE;
                  default: state_d = EXT2;
               endcase
            end
            EXT3: begin
               case (sensors)
                  2'b00: begin
                     state_d    = IDLE;
                     exit_evt_d = 1'b1;
                  end
                  2'b11:   state_d = EXT2;
                  2'b01:   state_d = IDLE;
                  default: state_d = EXT3;
               endcase
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign enter_evt = enter_evt_q;
   assign exit_evt  = exit_evt_q;

endmodule : gate_sensor_fsm

// File: rtl/parking_occupancy.sv
// Saturating parking occupancy counter with empty/full flags, event/error pulses
// and a daily entry total, fed by the gate sensor FSM.
module parking_occupancy
   import parking_pkg::*;
#(
   parameter int unsigned CAPACITY = DEFAULT_CAPACITY,
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned TOT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sensor_outer,
   input  logic             sensor_inner,
   input  logic             day_clear,
   output logic [CNT_W-1:0] occupancy,
   output logic             slot_empty,
   output logic             slot_full,
   output logic             car_entered,
   output logic             car_exited,
   output logic             overflow_err,
   output logic             underflow_err,
   output logic [TOT_W-1:0] total_entries
);

   localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);
   localparam logic [TOT_W-1:0] TOT_MAX_C = {TOT_W{1'b1}};

   sensor_pair_t     sensors_c;
   logic             enter_evt;
   logic             exit_evt;

   logic [CNT_W-1:0] occupancy_q, occupancy_d;
   logic [TOT_W-1:0] total_q, total_d;
   logic             slot_empty_q, slot_empty_d;
   logic             slot_full_q, slot_full_d;
   logic             car_entered_q, car_entered_d;
   logic             car_exited_q, car_exited_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   assign sensors_c = {sensor_outer, sensor_inner};

   gate_sensor_fsm u_gate_fsm (
      .clk       (clk),
      .reset     (reset),
      .sensors   (sensors_c),
      .clear     (day_clear),
      .enter_evt (enter_evt),
      .exit_evt  (exit_evt)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         occupancy_q   <= '0;
         total_q       <= '0;
         slot_empty_q  <= 1'b1;
         slot_full_q   <= 1'b0;
         car_entered_q <= 1'b0;
         car_exited_q  <= 1'b0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         occupancy_q   <= occupancy_d;
         total_q       <= total_d;
         slot_empty_q  <= slot_empty_d;
         slot_full_q   <= slot_full_d;
         car_entered_q <= car_entered_d;
         car_exited_q  <= car_exited_d;
         overflow_q    <= overflow_d;
         underflow_q   <= underflow_d;
      end
   end

   // day_clear discards any event that lands in the same cycle.
   always_comb begin
      occupancy_d   = occupancy_q;
      total_d       = total_q;
      car_entered_d = 1'b0;
      car_exited_d  = 1'b0;
      overflow_d    = 1'b0;
      underflow_d   = 1'b0;
      if (day_clear) begin
         occupancy_d = '0;
         total_d     = '0;
      end else if (enter_evt) begin
         if (occupancy_q < CAP_C) begin
            occupancy_d   = occupancy_q + CNT_W'(1);
            car_entered_d = 1'b1;
            if (total_q != TOT_MAX_C) begin
               total_d = total_q + TOT_W'(1);
            end
         end else begin
            overflow_d = 1'b1;
         end
      end else if (exit_evt) begin
         if (occupancy_q != '0) begin
            occupancy_d  = occupancy_q - CNT_W'(1);
            car_exited_d = 1'b1;
         end else begin
            underflow_d = 1'b1;
         end
      end
      // Flags track the next registered occupancy so they change on the same edge.
      slot_empty_d = (occupancy_d == '0);
      slot_full_d  = (occupancy_d == CAP_C);
   end

   assign occupancy     = occupancy_q;
   assign total_entries = total_q;
   assign slot_empty    = slot_empty_q;
   assign slot_full     = slot_full_q;
   assign car_entered   = car_entered_q;
   assign car_exited    = car_exited_q;
   assign overflow_err  = overflow_q;
   assign underflow_err = underflow_q;

endmodule : parking_occupancy

// File: doc/parking_occupancy.md
# parking_occupancy

Producer of the `slot_empty` / `slot_full` status consumed by the rush-hour tracker. It watches a two-beam gate sensor pair (outer, inner), decodes complete car entries and exits, and maintains a saturating occupancy count. It drives the empty/full flags, per-event pulses and a daily entry total. It sits between the gate sensor inputs and the rush-hour / display logic.

## Interface
- `CAPACITY`, default 3: number of parking slots (≥1).
- `CNT_W`, default 4: occupancy width; must satisfy 2^CNT_W > CAPACITY.
- `TOT_W`, default 8: width of the daily entry total.

- `clk`  input  1: system clock.
- `reset`  input  1: synchronous, active-low; 0 at a rising edge resets the block.
- `sensor_outer`  input  1: outer beam, 1 = blocked. Already synchronized and debounced upstream.
- `sensor_inner`  input  1: inner beam, 1 = blocked. Same conditioning as `sensor_outer`.
- `day_clear`  input  1: end-of-day clear; active-high, sampled each edge.
- `occupancy`  output  CNT_W: cars currently parked.
- `slot_empty`  output  1: occupancy == 0.
- `slot_full`  output  1: occupancy == CAPACITY.
- `car_entered`  output  1: one-cycle pulse on an accepted entry.
- `car_exited`  output  1: one-cycle pulse on an accepted exit.
- `overflow_err`  output  1: one-cycle pulse; entry completed while full.
- `underflow_err`  output  1: one-cycle pulse; exit completed while empty.
- `total_entries`  output  TOT_W: accepted entries since the last reset or clear; saturates at all-ones.

## Operation
- Sensor pair notation is {outer, inner}.
- Gate FSM states: IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3.
- IDLE: 10 → ENT1; 01 → EXT1; 00 or 11 → stay (11 from IDLE is a glitch and is ignored).
- ENT1: 11 → ENT2; 00 or 01 → IDLE (abort); 10 → stay.
- ENT2: 01 → ENT3; 10 → ENT1 (car reversing); 00 → IDLE; 11 → stay.
- ENT3: 00 → IDLE and raise the entry event; 11 → ENT2; 10 → IDLE (abort); 01 → stay.
- EXT1..EXT3: mirror of ENT1..ENT3 with outer and inner swapped. EXT3 on 00 → IDLE and raises the exit event.
- Aborted or reversed sequences never change occupancy.
- Accepted entry: occupancy < CAPACITY. Then occupancy +1, `car_entered` pulses, `total_entries` +1 (saturating).
- Entry at full: occupancy holds, `overflow_err` pulses, `total_entries` unchanged.
- Accepted exit: occupancy > 0. Then occupancy −1, `car_exited` pulses.
- Exit at empty: occupancy holds, `underflow_err` pulses.
- Entry and exit events are mutually exclusive, because there is a single gate FSM.
- `day_clear`: at the next edge, occupancy, `total_entries` and the FSM go to 0 / IDLE, and all pulses are 0. Any event already in flight in the same cycle is discarded. Priority: reset > day_clear > events.
- `slot_empty` and `slot_full` are decoded from registered occupancy only, with no combinational path from the sensors.

## Timing
- Reset values: occupancy 0, `slot_empty` 1, `slot_full` 0, all pulses 0, `total_entries` 0, FSM IDLE, internal event flops 0.
- Latency: sensors read 00 while in ENT3/EXT3 at edge E. The internal event registers at E. Occupancy, flags, pulses and the total update at edge E+1.
- Every pulse is high for exactly one cycle.
- The minimum sensor dwell per pattern is 1 cycle. Back-to-back cars (00 for one cycle, then 10) are both counted.
- Reset asserted mid-sequence returns the FSM to IDLE with no count change. A pending event flop is cleared.
- `day_clear` held for multiple cycles keeps everything cleared, and the FSM ignores the sensors while it is held.
- Width rule: occupancy compares use CNT_W-bit unsigned arithmetic. `total_entries` saturation compares against {TOT_W{1'b1}}.

## Structure
- Package `parking_pkg` holds:
  - `gate_state_e` enum (IDLE, ENT1..ENT3, EXT1..EXT3);
  - `sensor_pair_t` (2-bit packed struct: outer, inner);
  - default CAPACITY constant, shared with the rush-hour and display blocks.
- Sub-module `gate_sensor_fsm` (clk, reset, sensors, clear) contains the FSM above. It outputs registered `enter_evt` and `exit_evt` pulses.
- The top level holds the occupancy counter, flag decode, error pulses and the total counter.

## Test plan
- **Reset and idle:** hold reset low 5 cycles, sensors 00 → occupancy 0, `slot_empty` 1, `slot_full` 0, no pulses.
- **Three clean entries** (CAPACITY=3), each 10, 11, 01, 00 held 3 cycles → occupancy 1, 2, 3. `car_entered` pulses ×3, each 2 edges after 00. `slot_full` 1; `total_entries` 3.
- **Fourth entry at full** → `overflow_err` single pulse, occupancy stays 3, `total_entries` stays 3.
- **Exit sequence** 01, 11, 10, 00 from full → occupancy 2, `car_exited` pulse, `slot_full` 0. Exit from empty after draining → `underflow_err` pulse, occupancy 0.
- **Reversal and abort:** 10, 11, 10, 00 → no pulse, occupancy unchanged. 10, 11, 01, 11, 01, 00 → one entry counted.
- **day_clear and reset mid-sequence:** `day_clear` pulse with occupancy 2 while in ENT2 → occupancy 0, FSM IDLE, `slot_empty` 1. Reset asserted in EXT3 just before 00 → no `car_exited` pulse.
